// File: rtl/display_serializer.sv
// ---------------------------------------------------------------------------
// display_serializer
//
// Takes one parallel frame for the front-panel LED display and shifts it out
// to the shift-register chains one chain at a time. For each chain, csel_o
// selects the chain, then sin_o/sclk_o shift the bits out MSB first, and then
// latch_o moves the shifted bits to the chain outputs. All logic runs in the
// 40 MHz domain.
//
// Ports
//   clk40m_i       40 MHz clock, rising edge
//   reset_i        synchronous reset, active high
//   frame_i        frame; chain c = frame_i[c*BITS_PER_CHAIN +: BITS_PER_CHAIN]
//   frame_valid_i  frame_i valid (upstream holds it until accepted)
//   frame_ready_o  idle, a frame is accepted on valid & ready
//   blank_req_i    upstream request to blank the display
//   frame_done_o   one-cycle pulse once the last chain is latched
//   busy_o         frame transmission in progress
//   latch_o        shift-register latch strobe
//   blank_o        display blank (high = dark)
//   csel_o         binary chain select
//   sclk_o         shift clock; chains sample sin_o on its rising edge
//   sin_o          serial data, MSB of each chain first
//
// Every output is a flop loaded from the next-state values, so all pins are
// glitch-free and change together on the clock edge.
// ---------------------------------------------------------------------------
module display_serializer #(
  parameter int NUM_CHAINS     = 8,
  parameter int BITS_PER_CHAIN = 16,
  parameter int CLK_DIV        = 4
) (
  input  logic                                 clk40m_i,
  input  logic                                 reset_i,
  input  logic [NUM_CHAINS*BITS_PER_CHAIN-1:0] frame_i,
  input  logic                                 frame_valid_i,
  output logic                                 frame_ready_o,
  input  logic                                 blank_req_i,
  output logic                                 frame_done_o,
  output logic                                 busy_o,
  output logic                                 latch_o,
  output logic                                 blank_o,
  output logic [2:0]                           csel_o,
  output logic                                 sclk_o,
  output logic                                 sin_o
);

  localparam int FW      = NUM_CHAINS * BITS_PER_CHAIN;
  localparam int CHAIN_W = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
  localparam int BIT_W   = (BITS_PER_CHAIN > 1) ? $clog2(BITS_PER_CHAIN) : 1;
  localparam int IDX_W   = (FW > 1) ? $clog2(FW) : 1;
  localparam int CNT_W   = $clog2(2 * CLK_DIV);

  localparam logic [CNT_W-1:0]   HALF_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]   HALF       = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0]   FULL_LAST  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CHAIN_W-1:0] CHAIN_LAST = CHAIN_W'(NUM_CHAINS - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(BITS_PER_CHAIN - 1);

  if (NUM_CHAINS < 1 || NUM_CHAINS > 8 || BITS_PER_CHAIN < 1 || CLK_DIV < 1) begin : gen_param_check
    $error("display_serializer: NUM_CHAINS must be 1..8, BITS_PER_CHAIN and CLK_DIV >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,  // csel settles before the first sclk edge
    ST_SHIFT,  // per bit: low half with sin set, then high half
    ST_LATCH,  // low half, then latch strobe high half
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;      // cycle within the current phase
  logic [BIT_W-1:0]   bit_q, bit_d;      // bit being shifted, counts down
  logic [CHAIN_W-1:0] chain_q, chain_d;
  logic [FW-1:0]      frame_q;
  logic               frame_seen_q;
  logic               accept;
  logic [IDX_W-1:0]   bit_idx;

  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       latch_q, latch_d;
  logic       blank_q;
  logic [2:0] csel_q, csel_d;
  logic       sclk_q, sclk_d;
  logic       sin_q, sin_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    chain_d = chain_q;
    accept  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        bit_d   = '0;
        chain_d = '0;
        // ready_q rather than the state alone: the cycle right after reset
        // is IDLE but not yet advertising ready.
        if (frame_valid_i && ready_q) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = BIT_LAST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (bit_q == '0) state_d = ST_LATCH;
          else             bit_d   = bit_q - BIT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LATCH: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (chain_q == CHAIN_LAST) begin
            state_d = ST_DONE;
          end else begin
            chain_d = chain_q + CHAIN_W'(1);
            state_d = ST_SETUP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Output values for the coming cycle, derived from the next state.
    bit_idx = IDX_W'(int'(chain_d) * BITS_PER_CHAIN + int'(bit_d));
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    csel_d  = (state_d inside {ST_SETUP, ST_SHIFT, ST_LATCH}) ? 3'(chain_d) : 3'd0;
    sclk_d  = (state_d == ST_SHIFT) && (cnt_d >= HALF);
    latch_d = (state_d == ST_LATCH) && (cnt_d >= HALF);
    // frame_q is loaded on the accept edge; SETUP lasts at least one cycle,
    // so the buffer is always valid before the first SHIFT cycle.
    sin_d   = (state_d == ST_SHIFT) ? frame_q[bit_idx] : 1'b0;
  end

  always_ff @(posedge clk40m_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      chain_q      <= '0;
      frame_seen_q <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      latch_q      <= 1'b0;
      blank_q      <= 1'b1;
      csel_q       <= 3'd0;
      sclk_q       <= 1'b0;
      sin_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      chain_q <= chain_d;
      if (state_d == ST_DONE) frame_seen_q <= 1'b1;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      latch_q <= latch_d;
      blank_q <= blank_req_i | ~frame_seen_q;
      csel_q  <= csel_d;
      sclk_q  <= sclk_d;
      sin_q   <= sin_d;
    end
  end

  // NOTE: the frame buffer has no reset; it is only read after an accept has
  // overwritten it, and a reset returns the FSM to IDLE, which discards it.
  always_ff @(posedge clk40m_i) begin
    if (accept && !reset_i) frame_q <= frame_i;
  end

  assign frame_ready_o = ready_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = done_q;
  assign latch_o       = latch_q;
  assign blank_o       = blank_q;
  assign csel_o        = csel_q;
  assign sclk_o        = sclk_q;
  assign sin_o         = sin_q;

endmodule

// File: tb/tb_display_serializer.sv
// ---------------------------------------------------------------------------
// tb_display_serializer
//
// Self-checking bench for display_serializer with default parameters.
// Expected serial streams, latch pulses and timing come from the frame
// contents and the timing rules: chain c, bit order MSB first, D*(2B+3)
// cycles per chain, done in the (N*D*(2B+3)+1)-th cycle after the accept edge.
// Outputs are sampled on the falling clock edge, inputs driven there too.
// ---------------------------------------------------------------------------
module tb_display_serializer;

  localparam int N         = 8;
  localparam int B         = 16;
  localparam int D         = 4;
  localparam int FW        = N * B;
  localparam int CHAIN_CYC = D * (2 * B + 3);
  localparam int DONE_N    = N * CHAIN_CYC + 1;  // 1121

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [FW-1:0] frame_i = '0;
  logic          frame_valid_i = 1'b0;
  logic          blank_req_i = 1'b0;
  logic          frame_ready_o, frame_done_o, busy_o, latch_o, blank_o;
  logic [2:0]    csel_o;
  logic          sclk_o, sin_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit seen_m = 1'b0;  // model: a complete frame has gone out since reset

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  display_serializer #(
    .NUM_CHAINS    (N),
    .BITS_PER_CHAIN(B),
    .CLK_DIV       (D)
  ) dut (
    .clk40m_i     (clk),
    .reset_i      (reset_i),
    .frame_i      (frame_i),
    .frame_valid_i(frame_valid_i),
    .frame_ready_o(frame_ready_o),
    .blank_req_i  (blank_req_i),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o),
    .latch_o      (latch_o),
    .blank_o      (blank_o),
    .csel_o       (csel_o),
    .sclk_o       (sclk_o),
    .sin_o        (sin_o)
  );

  // {ready, busy, done, latch, blank, csel, sclk, sin}
  localparam logic [9:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};

  function automatic logic [9:0] out_vec();
    return {frame_ready_o, busy_o, frame_done_o, latch_o, blank_o, csel_o, sclk_o, sin_o};
  endfunction

  task automatic rand_frame(output logic [FW-1:0] f);
    for (int i = 0; i < FW; i += 32) f[i +: 32] = $urandom();
  endtask

  // Presents f with valid and returns on the falling edge just before the
  // accepting rising edge; acc_cyc is the cycle count at that falling edge.
  task automatic offer(input logic [FW-1:0] f, output int acc_cyc);
    int waited;
    frame_i       = f;
    frame_valid_i = 1'b1;
    waited        = 0;
    while (!frame_ready_o && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!frame_ready_o) begin
      errors++;
      $display("FAIL offer_timeout: frame_ready_o=%b after %0d cycles, required 1", frame_ready_o, waited);
    end
    acc_cyc = cyc;
  endtask

  // Follows one frame from its accept edge until the cycle after frame_done_o,
  // comparing every sclk rising edge, latch pulse and the done timing with the
  // model derived from frame f. blank_n > 0 raises blank_req_i at that cycle.
  task automatic watch_frame(input string tag, input logic [FW-1:0] f, input int blank_n,
                             input bit hold, input logic [FW-1:0] next_f);
    bit   exp_sin[$];
    int   exp_cs[$];
    int   rise = 0, sclk_since = 0, lat_n = 0, lat_w = 0, lat_cs = 0;
    int   done_n = -1, extra_done = 0, cs_bad = 0, ready_early = 0, busy_bad = 0;
    bit   prev_sclk = 1'b0, prev_lat = 1'b0, finished = 1'b0;
    for (int c = 0; c < N; c++)
      for (int k = 0; k < B; k++) begin
        exp_sin.push_back(f[c * B + (B - 1 - k)]);
        exp_cs.push_back(c);
      end

    for (int n = 1; n <= DONE_N + 40; n++) begin
      @(negedge clk);
      if (sclk_o && !prev_sclk) begin
        if (rise < N * B) begin
          checks++;
          if ({csel_o, sin_o} !== {exp_cs[rise][2:0], exp_sin[rise]}) begin
            errors++;
            $display("FAIL %s_bit%0d: csel/sin=%0d/%b, required %0d/%b", tag, rise,
                     csel_o, sin_o, exp_cs[rise], exp_sin[rise]);
          end
        end
        rise++;
        sclk_since++;
      end
      if (latch_o) begin
        lat_w++;
        if (!prev_lat) lat_cs = int'(csel_o);
        else if (int'(csel_o) != lat_cs) cs_bad++;
      end
      if (!latch_o && prev_lat) begin
        checks++;
        if (lat_w != D || sclk_since != B || lat_cs != lat_n) begin
          errors++;
          $display("FAIL %s_latch%0d: width=%0d sclks=%0d csel=%0d, required %0d %0d %0d",
                   tag, lat_n, lat_w, sclk_since, lat_cs, D, B, lat_n);
        end
        lat_n++;
        lat_w      = 0;
        sclk_since = 0;
      end
      if (done_n < 0 && frame_ready_o) ready_early++;
      if (done_n < 0 && !busy_o) busy_bad++;
      if (frame_done_o) begin
        if (done_n < 0) done_n = n;
        else extra_done++;
      end
      if (blank_n > 0 && n == blank_n) begin
        checks++;
        if (blank_o !== 1'b0) begin
          errors++;
          $display("FAIL %s_blank_before_req: blank_o=%b, required 0", tag, blank_o);
        end
      end
      if (blank_n > 0 && n == blank_n + 1) begin
        checks++;
        if (blank_o !== 1'b1) begin
          errors++;
          $display("FAIL %s_blank_after_req: blank_o=%b, required 1", tag, blank_o);
        end
      end
      if (done_n > 0 && n == done_n && !seen_m) begin
        checks++;
        if (blank_o !== 1'b1) begin
          errors++;
          $display("FAIL %s_blank_at_done: blank_o=%b, required 1", tag, blank_o);
        end
      end
      if (done_n > 0 && n == done_n + 1) begin
        checks++;
        if ({frame_ready_o, busy_o, blank_o} !== {1'b1, 1'b0, blank_req_i}) begin
          errors++;
          $display("FAIL %s_after_done: ready/busy/blank=%b%b%b, required 10%b", tag,
                   frame_ready_o, busy_o, blank_o, blank_req_i);
        end
        finished = 1'b1;
        break;
      end
      // Drive inputs for the coming edge after sampling.
      if (n == 1) begin
        if (hold) frame_i = next_f;
        else frame_valid_i = 1'b0;
      end
      if (blank_n > 0 && n == blank_n) blank_req_i = 1'b1;
      prev_sclk = sclk_o;
      prev_lat  = latch_o;
    end

    checks++;
    if (!finished || done_n != DONE_N || extra_done != 0) begin
      errors++;
      $display("FAIL %s_done_timing: done cycle=%0d extra=%0d, required %0d 0", tag,
               done_n, extra_done, DONE_N);
    end
    checks++;
    if (rise != N * B || lat_n != N || cs_bad != 0) begin
      errors++;
      $display("FAIL %s_counts: sclk rises=%0d latches=%0d csel moves in latch=%0d, required %0d %0d 0",
               tag, rise, lat_n, cs_bad, N * B, N);
    end
    checks++;
    if (ready_early != 0 || busy_bad != 0) begin
      errors++;
      $display("FAIL %s_handshake: ready cycles while busy=%0d busy low cycles=%0d, required 0 0",
               tag, ready_early, busy_bad);
    end
    if (finished) seen_m = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_values: outputs=%b, required %b", out_vec(), RESET_VEC);
    end
    reset_i = 1'b0;
    seen_m  = 1'b0;
    @(negedge clk);
    checks++;
    if ({frame_ready_o, busy_o} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_cycle: ready/busy=%b%b, required 10", frame_ready_o, busy_o);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (out_vec() !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle: outputs=%b, required 1000100000", out_vec());
    end
  endtask

  task automatic test_basic();
    logic [FW-1:0] f;
    int acc;
    f        = '0;
    f[15:0]  = 16'hA5C3;
    offer(f, acc);
    watch_frame("basic", f, 0, 1'b0, '0);
  endtask

  task automatic test_blank();
    logic [FW-1:0] f;
    int acc;
    rand_frame(f);
    offer(f, acc);
    watch_frame("blank", f, 500, 1'b0, '0);
    blank_req_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (blank_o !== 1'b0) begin
      errors++;
      $display("FAIL blank_release: blank_o=%b, required 0", blank_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] f1, f2;
    int acc1, acc2;
    rand_frame(f1);
    rand_frame(f2);
    offer(f1, acc1);
    watch_frame("b2b_first", f1, 0, 1'b1, f2);
    offer(f2, acc2);
    checks++;
    if (acc2 - acc1 != DONE_N + 1) begin
      errors++;
      $display("FAIL b2b_accept_gap: %0d cycles, required %0d", acc2 - acc1, DONE_N + 1);
    end
    watch_frame("b2b_second", f2, 0, 1'b0, '0);
  endtask

  task automatic test_reset_midframe();
    logic [FW-1:0] f;
    int acc, dones, busys;
    rand_frame(f);
    offer(f, acc);
    for (int n = 1; n <= 450; n++) begin
      @(negedge clk);
      if (n == 1) frame_valid_i = 1'b0;
    end
    checks++;
    if ({csel_o, busy_o} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL midreset_chain3: csel/busy=%0d/%b, required 3/1", csel_o, busy_o);
    end
    reset_i = 1'b1;
    @(negedge clk);
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL midreset_values: outputs=%b, required %b", out_vec(), RESET_VEC);
    end
    reset_i = 1'b0;
    seen_m  = 1'b0;
    dones   = 0;
    busys   = 0;
    repeat (DONE_N) begin
      @(negedge clk);
      if (frame_done_o) dones++;
      if (busy_o) busys++;
    end
    checks++;
    if (dones != 0 || busys != 0 || {frame_ready_o, blank_o} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_after: dones=%0d busy=%0d ready/blank=%b%b, required 0 0 11",
               dones, busys, frame_ready_o, blank_o);
    end
    rand_frame(f);
    offer(f, acc);
    watch_frame("midreset_new", f, 0, 1'b0, '0);
  endtask

  task automatic test_reset_with_valid();
    logic [FW-1:0] f;
    int busys;
    rand_frame(f);
    frame_i       = f;
    frame_valid_i = 1'b1;
    reset_i       = 1'b1;
    @(negedge clk);
    frame_valid_i = 1'b0;
    reset_i       = 1'b0;
    seen_m        = 1'b0;
    busys         = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy_o || sclk_o) busys++;
    end
    checks++;
    if (busys != 0 || {frame_ready_o, blank_o} !== 2'b11) begin
      errors++;
      $display("FAIL reset_vs_valid: busy/sclk cycles=%0d ready/blank=%b%b, required 0 11",
               busys, frame_ready_o, blank_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank();
    test_back_to_back();
    test_reset_midframe();
    test_reset_with_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
